// File: rtl/lookup_cfg_writer.sv
// -----------------------------------------------------------------------------
// lookup_cfg_writer
//
// Control-plane writer for one match-action stage's lookup control channel.
// Configuration packets arrive on a 64b valid/ready stream. A packet starts with
// a header beat ([63:56] opcode, [55:52] stage, [51:48] addr). It is followed by
// either a TCAM entry (KEY_BEATS key beats then KEY_BEATS mask beats, opcode 01)
// or an action-RAM word (ACT_BEATS beats, opcode 02). A complete, well-formed
// packet for this stage produces a single-cycle write strobe toward the lookup
// engine. Packets addressed to other stages are dropped silently.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready   config stream (valid/ready)
//   lookup_din, lookup_din_mask          TCAM key/mask, zero-extended above KEY_LEN
//   lookup_din_addr, lookup_din_en       TCAM entry index, 1-cycle write strobe
//   action_data_in, action_addr, action_en  action RAM word/index/strobe
//   cfg_ok_cnt, cfg_err_cnt              saturating completed-write / malformed counters
//
// Handshake: a beat transfers on a rising clk edge where s_tvalid & s_tready are
// both high. The source holds s_tdata/s_tlast stable while s_tvalid is high and
// s_tready is low; s_tready is low only during reset and in the WRITE cycle.
// -----------------------------------------------------------------------------
module lookup_cfg_writer #(
    parameter int STAGE   = 0,
    parameter int DATA_W  = 64,
    parameter int KEY_LEN = 197,
    parameter int ACT_LEN = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [1023:0]        lookup_din,
    output logic [1023:0]        lookup_din_mask,
    output logic [3:0]           lookup_din_addr,
    output logic                 lookup_din_en,
    output logic [ACT_LEN*25-1:0] action_data_in,
    output logic [3:0]           action_addr,
    output logic                 action_en,
    output logic [15:0]          cfg_ok_cnt,
    output logic [15:0]          cfg_err_cnt
);

    localparam int ACT_W     = ACT_LEN * 25;
    localparam int KEY_BEATS = (KEY_LEN + DATA_W - 1) / DATA_W;
    localparam int ACT_BEATS = (ACT_W + DATA_W - 1) / DATA_W;
    // Full beats before the final beat, and the bits the final beat contributes.
    localparam int KEY_HEAD  = (KEY_BEATS - 1) * DATA_W;
    localparam int KEY_TAIL  = KEY_LEN - KEY_HEAD;
    localparam int ACT_HEAD  = (ACT_BEATS - 1) * DATA_W;
    localparam int ACT_TAIL  = ACT_W - ACT_HEAD;

    localparam logic [7:0] OP_TCAM  = 8'h01;
    localparam logic [7:0] OP_ACT   = 8'h02;
    localparam logic [3:0] STAGE_ID = STAGE[3:0];

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_MASK = 3'd2,
        LOAD_ACT  = 3'd3,
        WRITE     = 3'd4,
        DISCARD   = 3'd5
    } state_t;

    // Current FSM state, kept as a named enum so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic             ready_q;     // low during reset and for one cycle after
    logic [3:0]       cnt;         // beat index within the current LOAD_* state
    logic             op_act_q;    // 1: action word packet, 0: TCAM packet
    logic [3:0]       addr_q;
    logic             fire;
    logic             err_inc;
    logic             commit;      // final beat of a well-formed packet accepted
    logic             last_key;
    logic             last_act;
    logic [7:0]       hdr_op;
    logic [3:0]       hdr_stage;

    // Assembly buffers; the final beat is consumed straight from s_tdata so
    // the output registers are valid in the WRITE cycle.
    logic [KEY_LEN-1:0]  key_buf;
    logic [KEY_HEAD-1:0] mask_buf;
    logic [ACT_HEAD-1:0] act_buf;
    logic [KEY_LEN-1:0]  mask_full;
    logic [ACT_W-1:0]    act_full;

    assign fire      = s_tvalid & s_tready;
    assign hdr_op    = s_tdata[63:56];
    assign hdr_stage = s_tdata[55:52];
    assign last_key  = (cnt == 4'(KEY_BEATS - 1));
    assign last_act  = (cnt == 4'(ACT_BEATS - 1));
    assign mask_full = {s_tdata[KEY_TAIL-1:0], mask_buf};
    assign act_full  = {s_tdata[ACT_TAIL-1:0], act_buf};

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (fire) begin
                    if (hdr_stage != STAGE_ID) begin
                        state_next = s_tlast ? IDLE : DISCARD;
                    end else if (hdr_op == OP_TCAM || hdr_op == OP_ACT) begin
                        if (s_tlast) begin
                            err_inc = 1'b1;          // header-only packet
                        end else begin
                            state_next = (hdr_op == OP_TCAM) ? LOAD_KEY : LOAD_ACT;
                        end
                    end else begin
                        err_inc    = 1'b1;
                        state_next = s_tlast ? IDLE : DISCARD;
                    end
                end
            end
            LOAD_KEY: begin
                if (fire) begin
                    if (s_tlast) begin
                        err_inc    = 1'b1;
                        state_next = IDLE;
                    end else if (last_key) begin
                        state_next = LOAD_MASK;
                    end
                end
            end
            LOAD_MASK: begin
                if (fire) begin
                    if (last_key) begin
                        if (s_tlast) begin
                            commit     = 1'b1;
                            state_next = WRITE;
                        end else begin
                            err_inc    = 1'b1;
                            state_next = DISCARD;
                        end
                    end else if (s_tlast) begin
                        err_inc    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LOAD_ACT: begin
                if (fire) begin
                    if (last_act) begin
                        if (s_tlast) begin
                            commit     = 1'b1;
                            state_next = WRITE;
                        end else begin
                            err_inc    = 1'b1;
                            state_next = DISCARD;
                        end
                    end else if (s_tlast) begin
                        err_inc    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            DISCARD: begin
                if (fire && s_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- output comb
    always_comb begin
        s_tready      = ready_q && (state != WRITE);
        lookup_din_en = (state == WRITE) && !op_act_q;
        action_en     = (state == WRITE) && op_act_q;
    end

    // ------------------------------------------------------- control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            cnt      <= 4'd0;
            op_act_q <= 1'b0;
            addr_q   <= 4'd0;
        end else begin
            ready_q <= 1'b1;
            if (state_next != state) begin
                cnt <= 4'd0;
            end else if (fire && (state == LOAD_KEY || state == LOAD_MASK ||
                                  state == LOAD_ACT)) begin
                cnt <= cnt + 4'd1;
            end
            if (state == IDLE && fire) begin
                op_act_q <= (hdr_op == OP_ACT);
                addr_q   <= s_tdata[51:48];
            end
        end
    end

    // ------------------------------------------------------- assembly buffers
    always_ff @(posedge clk) begin
        if (fire) begin
            for (int i = 0; i < KEY_BEATS - 1; i++) begin
                if (state == LOAD_KEY && cnt == 4'(i)) begin
                    key_buf[i*DATA_W +: DATA_W] <= s_tdata;
                end
                if (state == LOAD_MASK && cnt == 4'(i)) begin
                    mask_buf[i*DATA_W +: DATA_W] <= s_tdata;
                end
            end
            if (state == LOAD_KEY && last_key) begin
                key_buf[KEY_LEN-1 -: KEY_TAIL] <= s_tdata[KEY_TAIL-1:0];
            end
            for (int i = 0; i < ACT_BEATS - 1; i++) begin
                if (state == LOAD_ACT && cnt == 4'(i)) begin
                    act_buf[i*DATA_W +: DATA_W] <= s_tdata;
                end
            end
        end
    end

    // --------------------------------------------- output registers, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= 4'd0;
            action_data_in  <= '0;
            action_addr     <= 4'd0;
            cfg_ok_cnt      <= 16'd0;
            cfg_err_cnt     <= 16'd0;
        end else begin
            // Each target's registers change only on a commit of that target.
            if (commit && !op_act_q) begin
                lookup_din      <= 1024'(key_buf);
                lookup_din_mask <= 1024'(mask_full);
                lookup_din_addr <= addr_q;
            end
            if (commit && op_act_q) begin
                action_data_in <= act_full;
                action_addr    <= addr_q;
            end
            if (state == WRITE && cfg_ok_cnt != 16'hFFFF) begin
                cfg_ok_cnt <= cfg_ok_cnt + 16'd1;
            end
            if (err_inc && cfg_err_cnt != 16'hFFFF) begin
                cfg_err_cnt <= cfg_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// -----------------------------------------------------------------------------
// tb_lookup_cfg_writer
//
// Directed bench for lookup_cfg_writer (STAGE=0). Beats are driven on the
// falling edge and accepted on the next rising edge; DUT outputs are sampled
// on falling edges. A monitor counts strobes and flags any cycle where
// s_tready is low outside a WRITE strobe or both strobes are high.
// -----------------------------------------------------------------------------
module tb_lookup_cfg_writer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [1023:0] lookup_din;
    logic [1023:0] lookup_din_mask;
    logic [3:0]    lookup_din_addr;
    logic          lookup_din_en;
    logic [624:0]  action_data_in;
    logic [3:0]    action_addr;
    logic          action_en;
    logic [15:0]   cfg_ok_cnt;
    logic [15:0]   cfg_err_cnt;

    int checks = 0;
    int errors = 0;

    // Monitor state
    bit mon_en      = 1'b0;
    int lk_strobes  = 0;
    int act_strobes = 0;
    int bad_both    = 0;
    int bad_ready   = 0;

    logic [63:0]   pkt [0:15];
    logic [1023:0] exp_din;
    logic [1023:0] exp_mask;
    logic [639:0]  exp_act;

    lookup_cfg_writer #(
        .STAGE   (0),
        .DATA_W  (64),
        .KEY_LEN (197),
        .ACT_LEN (25)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .lookup_din      (lookup_din),
        .lookup_din_mask (lookup_din_mask),
        .lookup_din_addr (lookup_din_addr),
        .lookup_din_en   (lookup_din_en),
        .action_data_in  (action_data_in),
        .action_addr     (action_addr),
        .action_en       (action_en),
        .cfg_ok_cnt      (cfg_ok_cnt),
        .cfg_err_cnt     (cfg_err_cnt)
    );

    // ------------------------------------------------------ clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (lookup_din_en) lk_strobes++;
            if (action_en) act_strobes++;
            if (lookup_din_en && action_en) bad_both++;
            if (s_tready == (lookup_din_en || action_en)) bad_ready++;
        end
    end

    // ------------------------------------------------------------ checking
    task automatic chk(input string tag, input logic [639:0] obs,
                       input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------- drivers
    task automatic send_beat(input logic [63:0] d, input logic last,
                             input int max_gap);
        int n;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        @(negedge clk);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        n = 0;
        while (!s_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (s_tready === 1'b1) else begin
            errors++;
            $error("FAIL ready_timeout observed=%b expected=1", s_tready);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Sends pkt[0..n-1]; tlast on the final beat only when last_flag is set.
    task automatic send_pkt(input int n, input int max_gap, input logic last_flag);
        for (int i = 0; i < n; i++) begin
            send_beat(pkt[i], (i == n - 1) && last_flag, max_gap);
        end
    endtask

    // Checks the WRITE cycle of a TCAM packet against exp_din/exp_mask.
    task automatic expect_tcam(input logic [3:0] addr, input string tag);
        @(negedge clk);
        chk({tag, "_din_en"},   640'(lookup_din_en), 640'(1));
        chk({tag, "_act_en"},   640'(action_en), 640'(0));
        chk({tag, "_ready"},    640'(s_tready), 640'(0));
        chk({tag, "_addr"},     640'(lookup_din_addr), 640'(addr));
        chk({tag, "_din_lo"},   lookup_din[639:0], exp_din[639:0]);
        chk({tag, "_din_hi"},   640'(lookup_din[1023:640]), 640'(0));
        chk({tag, "_mask_lo"},  lookup_din_mask[639:0], exp_mask[639:0]);
        chk({tag, "_mask_hi"},  640'(lookup_din_mask[1023:640]), 640'(0));
    endtask

    // Checks the WRITE cycle of an action packet against exp_act; the TCAM
    // outputs must still hold exp_din.
    task automatic expect_act(input logic [3:0] addr, input string tag);
        @(negedge clk);
        chk({tag, "_act_en"},   640'(action_en), 640'(1));
        chk({tag, "_din_en"},   640'(lookup_din_en), 640'(0));
        chk({tag, "_ready"},    640'(s_tready), 640'(0));
        chk({tag, "_addr"},     640'(action_addr), 640'(addr));
        chk({tag, "_data"},     640'(action_data_in), 640'(exp_act[624:0]));
        chk({tag, "_din_kept"}, lookup_din[639:0], exp_din[639:0]);
    endtask

    // -------------------------------------------------------- directed steps
    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        exp_din  = '0;
        exp_mask = '0;
        exp_act  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",  640'(s_tready), 640'(0));
        chk("rst_din_en", 640'(lookup_din_en), 640'(0));
        chk("rst_act_en", 640'(action_en), 640'(0));
        chk("rst_din",    lookup_din[639:0], 640'(0));
        chk("rst_act",    640'(action_data_in), 640'(0));
        chk("rst_ok",     640'(cfg_ok_cnt), 640'(0));
        chk("rst_err",    640'(cfg_err_cnt), 640'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("post_rst_ready", 640'(s_tready), 640'(1));

        // 1: TCAM write, addr 3. K3 upper bits must be dropped.
        pkt[0] = {8'h01, 4'h0, 4'h3, 48'h0};
        pkt[1] = 64'h0123_4567_89AB_CDEF;
        pkt[2] = 64'hFEDC_BA98_7654_3210;
        pkt[3] = 64'hA5A5_5A5A_F0F0_0F0F;
        pkt[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        pkt[5] = 64'h1111_2222_3333_4444;
        pkt[6] = 64'h5555_6666_7777_8888;
        pkt[7] = 64'h9999_AAAA_BBBB_CCCC;
        pkt[8] = 64'hDEAD_BEEF_0000_0015;
        exp_din  = '0;
        exp_din[63:0]     = 64'h0123_4567_89AB_CDEF;
        exp_din[127:64]   = 64'hFEDC_BA98_7654_3210;
        exp_din[191:128]  = 64'hA5A5_5A5A_F0F0_0F0F;
        exp_din[196:192]  = 5'h1F;
        exp_mask = '0;
        exp_mask[63:0]    = 64'h1111_2222_3333_4444;
        exp_mask[127:64]  = 64'h5555_6666_7777_8888;
        exp_mask[191:128] = 64'h9999_AAAA_BBBB_CCCC;
        exp_mask[196:192] = 5'h15;
        send_pkt(9, 0, 1'b1);
        expect_tcam(4'd3, "t1");
        chk("t1_ok_in_write", 640'(cfg_ok_cnt), 640'(0));
        @(negedge clk);
        chk("t1_din_en_off", 640'(lookup_din_en), 640'(0));
        chk("t1_ok",         640'(cfg_ok_cnt), 640'(1));
        chk("t1_din_hold",   lookup_din[639:0], exp_din[639:0]);

        // 2: action write, addr 15. A9 bits above 48 must be dropped.
        pkt[0] = {8'h02, 4'h0, 4'hF, 48'h0};
        exp_act = '0;
        for (int i = 0; i < 9; i++) begin
            pkt[i+1] = 64'hC0DE_0000_0000_0000 | (64'(i + 1) * 64'h0001_0203_0405_0607);
            exp_act[i*64 +: 64] = pkt[i+1];
        end
        pkt[10] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_act[624:576] = 49'h1_FFFF_FFFF_FFFF;
        send_pkt(11, 0, 1'b1);
        expect_act(4'd15, "t2");
        @(negedge clk);
        chk("t2_ok",        640'(cfg_ok_cnt), 640'(2));
        chk("t2_mask_kept", lookup_din_mask[639:0], exp_mask[639:0]);

        // 3: foreign stage, header + 10 beats
        pkt[0] = {8'h01, 4'h1, 4'h2, 48'h0};
        for (int i = 1; i < 11; i++) pkt[i] = 64'h0BAD_0000_0000_0000 + 64'(i);
        send_pkt(11, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("t3_ok",      640'(cfg_ok_cnt), 640'(2));
        chk("t3_err",     640'(cfg_err_cnt), 640'(0));
        chk("t3_lk_strb", 640'(lk_strobes), 640'(1));
        chk("t3_ac_strb", 640'(act_strobes), 640'(1));
        chk("t3_ready",   640'(bad_ready), 640'(0));

        // 4a: TCAM packet ending on key beat 2
        pkt[0] = {8'h01, 4'h0, 4'h5, 48'h0};
        pkt[1] = 64'h1;
        pkt[2] = 64'h2;
        send_pkt(3, 0, 1'b1);
        @(negedge clk);
        chk("t4a_err", 640'(cfg_err_cnt), 640'(1));
        // 4b: action packet with 12 data beats
        pkt[0] = {8'h02, 4'h0, 4'h6, 48'h0};
        for (int i = 1; i < 13; i++) pkt[i] = 64'h7777_0000_0000_0000 + 64'(i);
        send_pkt(13, 0, 1'b1);
        @(negedge clk);
        chk("t4b_err",  640'(cfg_err_cnt), 640'(2));
        chk("t4b_addr", 640'(action_addr), 640'(15));
        chk("t4b_data", 640'(action_data_in), 640'(exp_act[624:0]));
        // 4c: unknown opcode, single beat
        pkt[0] = {8'h7F, 4'h0, 4'h1, 48'h0};
        send_pkt(1, 0, 1'b1);
        @(negedge clk);
        chk("t4c_err", 640'(cfg_err_cnt), 640'(3));
        // 4d: valid opcode, tlast on header
        pkt[0] = {8'h01, 4'h0, 4'h1, 48'h0};
        send_pkt(1, 0, 1'b1);
        @(negedge clk);
        chk("t4d_err",     640'(cfg_err_cnt), 640'(4));
        chk("t4_lk_strb",  640'(lk_strobes), 640'(1));
        chk("t4_ac_strb",  640'(act_strobes), 640'(1));
        chk("t4_ok",       640'(cfg_ok_cnt), 640'(2));
        // 4e: following valid TCAM packet, addr 7
        pkt[0] = {8'h01, 4'h0, 4'h7, 48'h0};
        pkt[1] = 64'h0000_0000_0000_0001;
        pkt[2] = 64'h0000_0000_0000_0002;
        pkt[3] = 64'h0000_0000_0000_0003;
        pkt[4] = 64'h0000_0000_0000_0004;
        pkt[5] = 64'hFFFF_0000_FFFF_0000;
        pkt[6] = 64'h0000_FFFF_0000_FFFF;
        pkt[7] = 64'hF0F0_F0F0_F0F0_F0F0;
        pkt[8] = 64'h0000_0000_0000_000A;
        exp_din  = '0;
        exp_din[63:0]     = 64'h1;
        exp_din[127:64]   = 64'h2;
        exp_din[191:128]  = 64'h3;
        exp_din[196:192]  = 5'h04;
        exp_mask = '0;
        exp_mask[63:0]    = 64'hFFFF_0000_FFFF_0000;
        exp_mask[127:64]  = 64'h0000_FFFF_0000_FFFF;
        exp_mask[191:128] = 64'hF0F0_F0F0_F0F0_F0F0;
        exp_mask[196:192] = 5'h0A;
        send_pkt(9, 0, 1'b1);
        expect_tcam(4'd7, "t4e");
        @(negedge clk);
        chk("t4e_ok",  640'(cfg_ok_cnt), 640'(3));
        chk("t4e_err", 640'(cfg_err_cnt), 640'(4));

        // 5: two back-to-back action packets with random valid gaps
        pkt[0] = {8'h02, 4'h0, 4'h1, 48'h0};
        exp_act = '0;
        for (int i = 0; i < 10; i++) begin
            pkt[i+1] = {32'h5100_0000 + 32'(i), 32'h0F0F_0000 + 32'(i * 3)};
            exp_act[i*64 +: 64] = pkt[i+1];
        end
        exp_act[639:625] = '0;
        send_pkt(11, 2, 1'b1);
        expect_act(4'd1, "t5a");
        pkt[0] = {8'h02, 4'h0, 4'h2, 48'h0};
        exp_act = '0;
        for (int i = 0; i < 10; i++) begin
            pkt[i+1] = {32'h5200_0000 + 32'(i * 7), 32'hABCD_0000 + 32'(i)};
            exp_act[i*64 +: 64] = pkt[i+1];
        end
        exp_act[639:625] = '0;
        send_pkt(11, 2, 1'b1);
        expect_act(4'd2, "t5b");
        @(negedge clk);
        chk("t5_ok",     640'(cfg_ok_cnt), 640'(5));
        chk("t5_ready",  640'(bad_ready), 640'(0));
        chk("t5_ac_str", 640'(act_strobes), 640'(3));

        // 6: reset in the middle of LOAD_MASK
        pkt[0] = {8'h01, 4'h0, 4'h9, 48'h0};
        for (int i = 1; i < 7; i++) pkt[i] = 64'h6666_0000_0000_0000 + 64'(i);
        send_pkt(7, 0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t6_ready",   640'(s_tready), 640'(0));
        chk("t6_din_en",  640'(lookup_din_en), 640'(0));
        chk("t6_act_en",  640'(action_en), 640'(0));
        chk("t6_din",     lookup_din[639:0], 640'(0));
        chk("t6_mask",    lookup_din_mask[639:0], 640'(0));
        chk("t6_din_adr", 640'(lookup_din_addr), 640'(0));
        chk("t6_act",     640'(action_data_in), 640'(0));
        chk("t6_act_adr", 640'(action_addr), 640'(0));
        chk("t6_ok",      640'(cfg_ok_cnt), 640'(0));
        chk("t6_err",     640'(cfg_err_cnt), 640'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        pkt[0] = {8'h01, 4'h0, 4'h4, 48'h0};
        pkt[1] = 64'hAAAA_AAAA_AAAA_AAAA;
        pkt[2] = 64'h5555_5555_5555_5555;
        pkt[3] = 64'h0000_0000_FFFF_FFFF;
        pkt[4] = 64'h0000_0000_0000_0013;
        pkt[5] = 64'h8000_0000_0000_0001;
        pkt[6] = 64'h4000_0000_0000_0002;
        pkt[7] = 64'h2000_0000_0000_0004;
        pkt[8] = 64'h0000_0000_0000_0008;
        exp_din  = '0;
        exp_din[63:0]     = 64'hAAAA_AAAA_AAAA_AAAA;
        exp_din[127:64]   = 64'h5555_5555_5555_5555;
        exp_din[191:128]  = 64'h0000_0000_FFFF_FFFF;
        exp_din[196:192]  = 5'h13;
        exp_mask = '0;
        exp_mask[63:0]    = 64'h8000_0000_0000_0001;
        exp_mask[127:64]  = 64'h4000_0000_0000_0002;
        exp_mask[191:128] = 64'h2000_0000_0000_0004;
        exp_mask[196:192] = 5'h08;
        send_pkt(9, 0, 1'b1);
        expect_tcam(4'd4, "t6w");
        @(negedge clk);
        chk("t6w_ok",      640'(cfg_ok_cnt), 640'(1));
        chk("t6w_err",     640'(cfg_err_cnt), 640'(0));
        chk("t6w_act_kept", 640'(action_data_in), 640'(0));

        // Totals over the whole run
        repeat (2) @(negedge clk);
        chk("tot_lk_strobes",  640'(lk_strobes), 640'(3));
        chk("tot_act_strobes", 640'(act_strobes), 640'(3));
        chk("tot_both_high",   640'(bad_both), 640'(0));
        chk("tot_ready",       640'(bad_ready), 640'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
